// File: rtl/foo_pkg.sv
// Shared constants and types for the foo key-match requester.
package foo_pkg;

  localparam int unsigned KeyW    = 4;
  // One full responder counter period.
  localparam int unsigned Timeout = 2 ** KeyW;
  localparam int unsigned LatW    = $clog2(Timeout + 1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRsp
  } foo_state_e;

  typedef struct packed {
    logic            timeout;
    logic [LatW-1:0] latency;
  } foo_rsp_t;

endpackage

// File: rtl/foo_shadow_ctr.sv
// Shadow copy of the responder's free-running down-counter.
// Only instantiated by foo_requester when FOO_REQ_SHADOW_PREDICT_EN is defined.
module foo_shadow_ctr
  import foo_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [KeyW-1:0] load_val_i,
  input  logic            clr_i,
  output logic [KeyW-1:0] cnt_o,
  output logic            vld_o
);

  logic [KeyW-1:0] cnt_q;
  logic            vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      if (load_i) begin
        cnt_q <= load_val_i;
        vld_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q - KeyW'(1);
        if (clr_i) begin
          vld_q <= 1'b0;
        end
      end
    end
  end

  assign cnt_o = cnt_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/foo_requester.sv
// Initiator side of the req/req_key/ack key-match handshake.
// Optional counter-prediction gating of req: define FOO_REQ_SHADOW_PREDICT_EN.
module foo_requester
  import foo_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [KeyW-1:0] cmd_key_i,
  output logic            req_o,
  output logic [KeyW-1:0] req_key_o,
  input  logic            ack_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic            rsp_timeout_o,
  output logic [LatW-1:0] rsp_latency_o
);

  foo_state_e      state_q;
  logic [KeyW-1:0] key_q;
  logic [LatW-1:0] lat_q;
  logic            cmd_ready_q;
  logic            req_q;
  logic            rsp_valid_q;
  foo_rsp_t        rsp_q;
  logic            ack_hit;

  // req_q is only ever set in StReq, so ack outside REQ or with req low is dropped here.
  assign ack_hit = ack_i && req_o;

`ifdef FOO_REQ_SHADOW_PREDICT_EN
  logic [KeyW-1:0] shadow_cnt;
  logic            shadow_vld;

  assign req_o = req_q && (!shadow_vld || (shadow_cnt == key_q));

  foo_shadow_ctr u_shadow_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ack_hit),
    .load_val_i (key_q - KeyW'(1)),
    .clr_i      (shadow_vld && req_o && !ack_i),
    .cnt_o      (shadow_cnt),
    .vld_o      (shadow_vld)
  );
`else
  assign req_o = req_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      key_q       <= '0;
      lat_q       <= '0;
      cmd_ready_q <= 1'b0;
      req_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid_i && cmd_ready_q) begin
            key_q       <= cmd_key_i;
            lat_q       <= '0;
            cmd_ready_q <= 1'b0;
            req_q       <= 1'b1;
            state_q     <= StReq;
          end
        end
        StReq: begin
          if (ack_hit) begin
            rsp_q       <= '{timeout: 1'b0, latency: lat_q};
            rsp_valid_q <= 1'b1;
            req_q       <= 1'b0;
            state_q     <= StRsp;
          end else if (lat_q == LatW'(Timeout - 1)) begin
            rsp_q       <= '{timeout: 1'b1, latency: LatW'(Timeout)};
            rsp_valid_q <= 1'b1;
            req_q       <= 1'b0;
            state_q     <= StRsp;
          end else if (lat_q != LatW'(Timeout)) begin
            lat_q <= lat_q + LatW'(1);
          end
        end
        StRsp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign req_key_o     = key_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_timeout_o = rsp_q.timeout;
  assign rsp_latency_o = rsp_q.latency;

endmodule
